// File: rtl/rcc_rst_ctrl_if.sv
// Reset-request and reset-output bundle of the RCC reset controller.
// master = request sources/consumers, slave = the controller.
interface rcc_rst_ctrl_if;
    logic pin_rst_req;
    logic pwr_bor_rst;
    logic obl_rst;
    logic lpwr1_rst;
    logic lpwr2_rst;
    logic iwdg1_out_rst;
    logic iwdg2_out_rst;
    logic wwdg1_out_rst;
    logic cpu1_sftrst;
    logic wwdg2_out_rst;
    logic cpu2_sftrst;
    logic d1_pwr_rdy;
    logic d2_pwr_rdy;
    logic d1_rst;
    logic d2_rst;
    logic cpu1_rst;
    logic cpu2_rst;
    logic nrst_out;
    logic rst_busy;
    logic pwr_timeout;

    modport master (
        output pin_rst_req, pwr_bor_rst, obl_rst,
        output lpwr1_rst, lpwr2_rst,
        output iwdg1_out_rst, iwdg2_out_rst,
        output wwdg1_out_rst, cpu1_sftrst,
        output wwdg2_out_rst, cpu2_sftrst,
        output d1_pwr_rdy, d2_pwr_rdy,
        input  d1_rst, d2_rst, cpu1_rst, cpu2_rst,
        input  nrst_out, rst_busy, pwr_timeout
    );

    modport slave (
        input  pin_rst_req, pwr_bor_rst, obl_rst,
        input  lpwr1_rst, lpwr2_rst,
        input  iwdg1_out_rst, iwdg2_out_rst,
        input  wwdg1_out_rst, cpu1_sftrst,
        input  wwdg2_out_rst, cpu2_sftrst,
        input  d1_pwr_rdy, d2_pwr_rdy,
        output d1_rst, d2_rst, cpu1_rst, cpu2_rst,
        output nrst_out, rst_busy, pwr_timeout
    );
endinterface

// File: rtl/rcc_rst_ctrl.sv
// RCC reset controller: system stretch, power wait, staged release.
// Optional power-ready timeout enabled by defining RCC_RST_TIMEOUT_EN.
module rcc_rst_ctrl #(
    parameter int SYS_PULSE = 20,
    parameter int CPU_PULSE = 8,
    parameter int REL_GAP   = 4,
    parameter int TO_CYCLES = 1024,
    parameter int CNT_W     = 11
) (
    input  logic          clk,
    input  logic          rst,
    rcc_rst_ctrl_if.slave bus
);

    localparam int LIM_A = (SYS_PULSE > REL_GAP) ? SYS_PULSE : REL_GAP;
    localparam int LIM_B = (LIM_A > TO_CYCLES) ? LIM_A : TO_CYCLES;

    localparam logic [CNT_W-1:0] SYS_LAST = CNT_W'(SYS_PULSE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(REL_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(LIM_B - 1);
    localparam logic [CNT_W-1:0] CPU_LOAD = CNT_W'(CPU_PULSE);
`ifdef RCC_RST_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_WAIT_PWR,
        ST_REL_GAP,
        ST_IDLE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] loc1_q, loc1_d;
    logic [CNT_W-1:0] loc2_q, loc2_d;
    logic             d_rst_q, d_rst_d;
    logic             cpu1_rst_q, cpu1_rst_d;
    logic             cpu2_rst_q, cpu2_rst_d;
    logic             nrst_q, nrst_d;
    logic             busy_q, busy_d;
    logic             to_q, to_d;

    logic             sys_req;
    logic             loc1_req;
    logic             loc2_req;
    logic             pwr_ok;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        sys_req = bus.pin_rst_req | bus.pwr_bor_rst | bus.obl_rst
                | bus.lpwr1_rst | bus.lpwr2_rst
                | bus.iwdg1_out_rst | bus.iwdg2_out_rst;
        loc1_req = bus.wwdg1_out_rst | bus.cpu1_sftrst;
        loc2_req = bus.wwdg2_out_rst | bus.cpu2_sftrst;
        pwr_ok   = bus.d1_pwr_rdy & bus.d2_pwr_rdy;
        cnt_inc  = (cnt_q >= CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

        state_d = state_q;
        cnt_d   = cnt_inc;
        to_d    = 1'b0;

        unique case (state_q)
            ST_ASSERT: begin
                if (sys_req) begin
                    cnt_d = '0;
                end else if (cnt_q == SYS_LAST) begin
                    state_d = ST_WAIT_PWR;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_PWR: begin
                if (pwr_ok) begin
                    state_d = ST_REL_GAP;
                    cnt_d   = '0;
`ifdef RCC_RST_TIMEOUT_EN
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_REL_GAP;
                    cnt_d   = '0;
                    to_d    = 1'b1;
                end
`else
                end else begin
                    cnt_d = cnt_q;
                end
`endif
            end
            ST_REL_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_ASSERT;
                cnt_d   = '0;
            end
        endcase

        // System requests pre-empt everything, including a timeout exit
        if (sys_req) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            to_d    = 1'b0;
        end

        loc1_d = (loc1_q != '0) ? loc1_q - CNT_W'(1) : '0;
        loc2_d = (loc2_q != '0) ? loc2_q - CNT_W'(1) : '0;
        if (state_q == ST_IDLE && loc1_req) loc1_d = CPU_LOAD;
        if (state_q == ST_IDLE && loc2_req) loc2_d = CPU_LOAD;
        if (sys_req) begin
            loc1_d = '0;
            loc2_d = '0;
        end

        d_rst_d    = state_d inside {ST_ASSERT, ST_WAIT_PWR};
        busy_d     = state_d != ST_IDLE;
        nrst_d     = state_d == ST_ASSERT;
        cpu1_rst_d = busy_d | (loc1_d != '0);
        cpu2_rst_d = busy_d | (loc2_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ASSERT;
            cnt_q      <= '0;
            loc1_q     <= '0;
            loc2_q     <= '0;
            d_rst_q    <= 1'b1;
            cpu1_rst_q <= 1'b1;
            cpu2_rst_q <= 1'b1;
            nrst_q     <= 1'b1;
            busy_q     <= 1'b1;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            loc1_q     <= loc1_d;
            loc2_q     <= loc2_d;
            d_rst_q    <= d_rst_d;
            cpu1_rst_q <= cpu1_rst_d;
            cpu2_rst_q <= cpu2_rst_d;
            nrst_q     <= nrst_d;
            busy_q     <= busy_d;
            to_q       <= to_d;
        end
    end

    assign bus.d1_rst      = d_rst_q;
    assign bus.d2_rst      = d_rst_q;
    assign bus.cpu1_rst    = cpu1_rst_q;
    assign bus.cpu2_rst    = cpu2_rst_q;
    assign bus.nrst_out    = nrst_q;
    assign bus.rst_busy    = busy_q;
    assign bus.pwr_timeout = to_q;

endmodule

// File: tb/tb_rcc_rst_ctrl.sv
// Bench for rcc_rst_ctrl: directed scenarios then random traffic,
// checked against an edge-index timing model.
module tb_rcc_rst_ctrl;

    localparam int SYS_PULSE = 20;
    localparam int CPU_PULSE = 8;
    localparam int REL_GAP   = 4;
    localparam int TO_CYCLES = 1024;

    localparam logic [10:0] S_NONE  = 11'd0;
    localparam logic [10:0] S_PIN   = 11'd1;
    localparam logic [10:0] S_IWDG1 = 11'd1 << 5;
    localparam logic [10:0] S_CPU1  = 11'd1 << 8;
    localparam logic [10:0] S_WWDG2 = 11'd1 << 9;
    localparam logic [10:0] S_CPU2  = 11'd1 << 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rcc_rst_ctrl_if bus ();

    rcc_rst_ctrl #(
        .SYS_PULSE(SYS_PULSE),
        .CPU_PULSE(CPU_PULSE),
        .REL_GAP  (REL_GAP),
        .TO_CYCLES(TO_CYCLES),
        .CNT_W    (11)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks = 0;
    int passed = 0;

    // Model: edge index, last system event, domain release edge,
    // and the edge before which each local pulse ends.
    int n = 0;
    int last_sys = 0;
    int dom_rel = -1;
    int l1_until = 0;
    int l2_until = 0;
    bit exp_to = 1'b0;

    int hi_nrst, hi_d, hi_c1, hi_c2, hi_to;

    task automatic chk(input string tag, input logic obs,
                       input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_int(input string tag, input int obs,
                           input int exp);
        checks++;
        assert (obs == exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clr_hi();
        hi_nrst = 0;
        hi_d    = 0;
        hi_c1   = 0;
        hi_c2   = 0;
        hi_to   = 0;
    endtask

    task automatic step(input logic [10:0] src, input logic [1:0] rdy,
                        input logic r);
        bit sys, l1, l2, idle_b, e_asrt, e_dom, e_busy;
        rst                = r;
        bus.pin_rst_req    = src[0];
        bus.pwr_bor_rst    = src[1];
        bus.obl_rst        = src[2];
        bus.lpwr1_rst      = src[3];
        bus.lpwr2_rst      = src[4];
        bus.iwdg1_out_rst  = src[5];
        bus.iwdg2_out_rst  = src[6];
        bus.wwdg1_out_rst  = src[7];
        bus.cpu1_sftrst    = src[8];
        bus.wwdg2_out_rst  = src[9];
        bus.cpu2_sftrst    = src[10];
        bus.d1_pwr_rdy     = rdy[0];
        bus.d2_pwr_rdy     = rdy[1];
        @(posedge clk);

        sys = |src[6:0];
        l1  = |src[8:7];
        l2  = |src[10:9];
        n++;
        exp_to = 1'b0;
        idle_b = (dom_rel >= 0) && (n - 1 >= dom_rel + REL_GAP);
        if (r || sys) begin
            last_sys = n;
            dom_rel  = -1;
            l1_until = 0;
            l2_until = 0;
        end else begin
            if (dom_rel < 0 && n - last_sys > SYS_PULSE) begin
                if (rdy == 2'b11) begin
                    dom_rel = n;
`ifdef RCC_RST_TIMEOUT_EN
                end else if (n - last_sys == SYS_PULSE + TO_CYCLES) begin
                    dom_rel = n;
                    exp_to  = 1'b1;
`endif
                end
            end
            if (idle_b && l1) l1_until = n + CPU_PULSE;
            if (idle_b && l2) l2_until = n + CPU_PULSE;
        end
        e_dom  = dom_rel < 0;
        e_asrt = e_dom && (n - last_sys < SYS_PULSE);
        e_busy = e_dom || (n < dom_rel + REL_GAP);

        #1;
        chk("nrst_out", bus.nrst_out, e_asrt);
        chk("d1_rst", bus.d1_rst, e_dom);
        chk("d2_rst", bus.d2_rst, e_dom);
        chk("cpu1_rst", bus.cpu1_rst, e_busy || (n < l1_until));
        chk("cpu2_rst", bus.cpu2_rst, e_busy || (n < l2_until));
        chk("rst_busy", bus.rst_busy, e_busy);
        chk("pwr_timeout", bus.pwr_timeout, exp_to);

        if (bus.nrst_out === 1'b1) hi_nrst++;
        if (bus.d1_rst === 1'b1) hi_d++;
        if (bus.cpu1_rst === 1'b1) hi_c1++;
        if (bus.cpu2_rst === 1'b1) hi_c2++;
        if (bus.pwr_timeout === 1'b1) hi_to++;
    endtask

    initial begin
        logic [10:0] s;
        logic [1:0]  rd;
        logic        rr;

        // Power-on reset, then staged release with power ready
        step(S_NONE, 2'b11, 1'b1);
        step(S_NONE, 2'b11, 1'b1);
        clr_hi();
        step(S_NONE, 2'b11, 1'b1);
        repeat (40) step(S_NONE, 2'b11, 1'b0);
        chk_int("por_nrst_len", hi_nrst, SYS_PULSE);
        chk_int("por_dom_len", hi_d, SYS_PULSE + 1);
        chk_int("por_cpu_len", hi_c1, SYS_PULSE + 1 + REL_GAP);

        // Overlapping local pulses in IDLE
        clr_hi();
        step(S_CPU1, 2'b11, 1'b0);
        step(S_NONE, 2'b11, 1'b0);
        step(S_NONE, 2'b11, 1'b0);
        step(S_WWDG2, 2'b11, 1'b0);
        repeat (15) step(S_NONE, 2'b11, 1'b0);
        chk_int("loc_cpu1_len", hi_c1, CPU_PULSE);
        chk_int("loc_cpu2_len", hi_c2, CPU_PULSE);
        chk_int("loc_dom_len", hi_d, 0);

        // Pin held 50 cycles
        clr_hi();
        repeat (50) step(S_PIN, 2'b11, 1'b0);
        repeat (80) step(S_NONE, 2'b11, 1'b0);
        chk_int("pin50_dom_len", hi_d, 50 + SYS_PULSE);
        chk_int("pin50_cpu_len", hi_c1, 50 + SYS_PULSE + REL_GAP);

        // Watchdog cancels a running CPU2 local pulse
        step(S_CPU2, 2'b11, 1'b0);
        repeat (3) step(S_NONE, 2'b11, 1'b0);
        step(S_IWDG1, 2'b11, 1'b0);
        repeat (40) step(S_NONE, 2'b11, 1'b0);

        // Domain 2 supply never ready
        clr_hi();
        step(S_PIN, 2'b11, 1'b0);
`ifdef RCC_RST_TIMEOUT_EN
        repeat (SYS_PULSE + TO_CYCLES + 10) step(S_NONE, 2'b01, 1'b0);
        chk_int("timeout_pulses", hi_to, 1);
`else
        repeat (200) step(S_NONE, 2'b01, 1'b0);
        chk_int("no_timeout", hi_to, 0);
        chk_int("wait_dom_len", hi_d, 201);
`endif
        repeat (30) step(S_NONE, 2'b11, 1'b0);

        // Synchronous reset during REL_GAP
        step(S_PIN, 2'b11, 1'b0);
        repeat (SYS_PULSE + 2) step(S_NONE, 2'b11, 1'b0);
        step(S_NONE, 2'b11, 1'b1);
        repeat (40) step(S_NONE, 2'b11, 1'b0);

        // Random traffic
        repeat (4000) begin
            s  = S_NONE;
            rd = 2'b11;
            rr = 1'b0;
            if ($urandom_range(0, 149) == 0)
                s[$urandom_range(0, 6)] = 1'b1;
            if ($urandom_range(0, 15) == 0)
                s[$urandom_range(7, 10)] = 1'b1;
            if ($urandom_range(0, 9) == 0) rd[0] = 1'b0;
            if ($urandom_range(0, 9) == 0) rd[1] = 1'b0;
            if ($urandom_range(0, 1499) == 0) rr = 1'b1;
            step(s, rd, rr);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
